mmu_pte_server: RTL and testbench

- Memory-side responder for the page-table walker's two request channels.
- PTE-read channel: services single 64-bit PTE loads and returns the data.
- Mark channel: performs the read-modify-write that sets the A and D bits in a PTE, then acknowledges.
- Sits between the walker and one 64-bit memory port (L2/L1D refill path); it is the only agent that writes PTEs on behalf of the walker.

---
 rtl/mmu_pte_server_pkg.sv | 39 +++
 rtl/mmu_pte_server_if.sv | 48 ++++
 rtl/mmu_pte_server_pte_req_latch.sv | 52 +++++
 rtl/mmu_pte_server.sv | 196 +++++++++++++++++++
 tb/tb_mmu_pte_server.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmu_pte_server_pkg.sv
// Shared types and PTE constants for the walker's PTE server.
// Holds the FSM encoding and the A/D mark helpers.
package mmu_pte_server_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        MK_RD_REQ,
        MK_RD_WAIT,
        MK_WR_REQ,
        MK_WR_WAIT,
        MK_ACK
    } pte_srv_state_t;

    localparam int PTE_V          = 0;
    localparam int PTE_A          = 6;
    localparam int PTE_D          = 7;
    localparam int PTE_ADDR_ALIGN = 3;

    // Dirty implies accessed: D set always drags A with it.
    function automatic logic [1:0] mark_bits(
        input logic dirty,
        input logic accessed
    );
        return {dirty, accessed | dirty};
    endfunction

    // A store is only worth issuing for a valid PTE missing a bit.
    function automatic logic needs_write(
        input logic [63:0] old,
        input logic [1:0]  nb
    );
        logic [1:0] cur;
        cur = old[PTE_D:PTE_A];
        return old[PTE_V] && ((cur | nb) != cur);
    endfunction

endpackage

// File: rtl/mmu_pte_server_if.sv
// Walker channels plus the memory port, bundled for the PTE server.
// master = walker/memory environment, slave = the server itself.
interface mmu_pte_server_if #(
    parameter int PA_WIDTH = 32
);
    logic                pte_req_valid;
    logic [PA_WIDTH-1:0] pte_req_addr;
    logic                pte_rsp_valid;
    logic [63:0]         pte_rsp_data;

    logic                mark_valid;
    logic                mark_accessed;
    logic                mark_dirty;
    logic [63:0]         mark_addr;
    logic                mark_rsp_valid;

    logic                port_req_valid;
    logic                port_req_ready;
    logic [PA_WIDTH-1:0] port_req_addr;
    logic                port_req_store;
    logic [63:0]         port_req_wdata;
    logic                port_rsp_valid;
    logic [63:0]         port_rsp_data;

    modport master (
        output pte_req_valid, pte_req_addr,
        input  pte_rsp_valid, pte_rsp_data,
        output mark_valid, mark_accessed,
        output mark_dirty, mark_addr,
        input  mark_rsp_valid,
        input  port_req_valid, port_req_addr,
        input  port_req_store, port_req_wdata,
        output port_req_ready,
        output port_rsp_valid, port_rsp_data
    );

    modport slave (
        input  pte_req_valid, pte_req_addr,
        output pte_rsp_valid, pte_rsp_data,
        input  mark_valid, mark_accessed,
        input  mark_dirty, mark_addr,
        output mark_rsp_valid,
        output port_req_valid, port_req_addr,
        output port_req_store, port_req_wdata,
        input  port_req_ready,
        input  port_rsp_valid, port_rsp_data
    );
endinterface

// File: rtl/mmu_pte_server_pte_req_latch.sv
// One-deep capture of a single-cycle request pulse and its payload.
// The pulse is visible combinationally so IDLE can take it at once.
module pte_req_latch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set_i,
    input  logic [W-1:0] data_i,
    input  logic         clr_i,
    output logic         pend_o,
    output logic [W-1:0] data_o,
    output logic         pend_nxt_o
);
    logic         pend_q;
    logic         pend_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next pending flag and payload capture on a fresh pulse.
    always_comb begin
        pend_d = (pend_q | set_i) & ~clr_i;
        data_d = data_q;
        if (set_i && !pend_q) begin
            data_d = data_i;
        end
    end

    // Pending flag and payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            data_q <= '0;
        end else begin
            pend_q <= pend_d;
            data_q <= data_d;
        end
    end

    assign pend_o     = pend_q | set_i;
    assign data_o     = pend_q ? data_q : data_i;
    assign pend_nxt_o = pend_d;

    // A pulse on an already-pending channel would be lost.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(set_i && pend_q))
            else $error("pte_req_latch: pulse while pending");
        end
    end

endmodule

// File: rtl/mmu_pte_server.sv
// Memory-side responder for walker PTE reads and A/D marking.
// Marks win arbitration; every output is driven from a register.
module mmu_pte_server
    import mmu_pte_server_pkg::*;
#(
    parameter int PA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            reset,
    mmu_pte_server_if.slave bus,
    output logic            busy
);
    localparam int AW = PA_WIDTH - PTE_ADDR_ALIGN;

    pte_srv_state_t state_q, state_d;

    logic                rd_pend, rd_clr, rd_pend_nxt;
    logic [AW-1:0]       rd_line;
    logic                mk_pend, mk_clr, mk_pend_nxt;
    logic [AW+1:0]       mk_data;

    logic                req_valid_q, req_valid_d;
    logic [PA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                req_store_q, req_store_d;
    logic [63:0]         req_wdata_q, req_wdata_d;
    logic [1:0]          nb_q, nb_d;
    logic                pte_vld_q, pte_vld_d;
    logic [63:0]         pte_data_q, pte_data_d;
    logic                mk_rsp_q, mk_rsp_d;
    logic                busy_q, busy_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{
        bus.mark_addr[63:PA_WIDTH],
        bus.mark_addr[PTE_ADDR_ALIGN-1:0],
        bus.pte_req_addr[PTE_ADDR_ALIGN-1:0]
    };

    pte_req_latch #(.W(AW)) u_rd_latch (
        .clk        (clk),
        .reset      (reset),
        .set_i      (bus.pte_req_valid),
        .data_i     (bus.pte_req_addr[PA_WIDTH-1:PTE_ADDR_ALIGN]),
        .clr_i      (rd_clr),
        .pend_o     (rd_pend),
        .data_o     (rd_line),
        .pend_nxt_o (rd_pend_nxt)
    );

    pte_req_latch #(.W(AW + 2)) u_mk_latch (
        .clk        (clk),
        .reset      (reset),
        .set_i      (bus.mark_valid),
        .data_i     ({bus.mark_dirty, bus.mark_accessed,
                      bus.mark_addr[PA_WIDTH-1:PTE_ADDR_ALIGN]}),
        .clr_i      (mk_clr),
        .pend_o     (mk_pend),
        .data_o     (mk_data),
        .pend_nxt_o (mk_pend_nxt)
    );

    // Next state, memory-port driver and response registers.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_store_d = req_store_q;
        req_wdata_d = req_wdata_q;
        nb_d        = nb_q;
        pte_vld_d   = 1'b0;
        pte_data_d  = pte_data_q;
        mk_rsp_d    = 1'b0;
        rd_clr      = 1'b0;
        mk_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mk_pend) begin
                    mk_clr = 1'b1;
                    nb_d   = mark_bits(mk_data[AW+1], mk_data[AW]);
                    if (nb_d == 2'b00) begin
                        state_d = MK_ACK;
                    end else begin
                        state_d     = MK_RD_REQ;
                        req_valid_d = 1'b1;
                        req_store_d = 1'b0;
                        req_addr_d  = {mk_data[AW-1:0],
                                       {PTE_ADDR_ALIGN{1'b0}}};
                    end
                end else if (rd_pend) begin
                    rd_clr      = 1'b1;
                    state_d     = RD_REQ;
                    req_valid_d = 1'b1;
                    req_store_d = 1'b0;
                    req_addr_d  = {rd_line, {PTE_ADDR_ALIGN{1'b0}}};
                end
            end
            RD_REQ: begin
                if (bus.port_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.port_rsp_valid) begin
                    pte_vld_d  = 1'b1;
                    pte_data_d = bus.port_rsp_data;
                    state_d    = IDLE;
                end
            end
            MK_RD_REQ: begin
                if (bus.port_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = MK_RD_WAIT;
                end
            end
            MK_RD_WAIT: begin
                if (bus.port_rsp_valid) begin
                    if (needs_write(bus.port_rsp_data, nb_q)) begin
                        state_d     = MK_WR_REQ;
                        req_valid_d = 1'b1;
                        req_store_d = 1'b1;
                        req_wdata_d = bus.port_rsp_data
                                    | (64'(nb_q) << PTE_A);
                    end else begin
                        state_d = MK_ACK;
                    end
                end
            end
            MK_WR_REQ: begin
                if (bus.port_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = MK_WR_WAIT;
                end
            end
            MK_WR_WAIT: begin
                if (bus.port_rsp_valid) begin
                    state_d = MK_ACK;
                end
            end
            MK_ACK: begin
                mk_rsp_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) | rd_pend_nxt | mk_pend_nxt;
    end

    // State and registered outputs; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_store_q <= 1'b0;
            req_wdata_q <= '0;
            nb_q        <= '0;
            pte_vld_q   <= 1'b0;
            pte_data_q  <= '0;
            mk_rsp_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_store_q <= req_store_d;
            req_wdata_q <= req_wdata_d;
            nb_q        <= nb_d;
            pte_vld_q   <= pte_vld_d;
            pte_data_q  <= pte_data_d;
            mk_rsp_q    <= mk_rsp_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.port_req_valid = req_valid_q;
    assign bus.port_req_addr  = req_addr_q;
    assign bus.port_req_store = req_store_q;
    assign bus.port_req_wdata = req_wdata_q;
    assign bus.pte_rsp_valid  = pte_vld_q;
    assign bus.pte_rsp_data   = pte_data_q;
    assign bus.mark_rsp_valid = mk_rsp_q;
    assign busy               = busy_q;

    // Memory responses are only meaningful in a waiting state.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!bus.port_rsp_valid ||
                    state_q inside {RD_WAIT, MK_RD_WAIT, MK_WR_WAIT})
            else $error("mmu_pte_server: stray port response");
        end
    end

endmodule

// File: tb/tb_mmu_pte_server.sv
// Directed bench for mmu_pte_server: reads, A/D marks, arbitration,
// backpressure and reset abandonment against hand-computed values.
module tb_mmu_pte_server;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    int n_pass  = 0;
    int n_total = 0;

    int          n_rd   = 0;
    int          n_st   = 0;
    int          n_mark = 0;
    logic [31:0] last_addr = '0;

    mmu_pte_server_if #(.PA_WIDTH(32)) bus ();

    mmu_pte_server #(.PA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Observes accepted port requests and mark completions.
    always @(posedge clk) begin
        if (bus.port_req_valid && bus.port_req_ready) begin
            if (bus.port_req_store) n_st++;
            else n_rd++;
            last_addr = bus.port_req_addr;
        end
        if (bus.mark_rsp_valid) n_mark++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic wait_req(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.port_req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, " req seen"}, 64'(ok), 64'd1);
    endtask

    task automatic accept();
        bus.port_req_ready = 1'b1;
        tick();
        bus.port_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [63:0] d);
        bus.port_rsp_valid = 1'b1;
        bus.port_rsp_data  = d;
        tick();
        bus.port_rsp_valid = 1'b0;
        bus.port_rsp_data  = '0;
    endtask

    task automatic do_mark(input string       tag,
                           input bit          acc,
                           input bit          dty,
                           input logic [63:0] addr,
                           input logic [63:0] old,
                           input bit          exp_store,
                           input logic [63:0] exp_wdata);
        int st0;
        int mk0;
        st0 = n_st;
        mk0 = n_mark;
        bus.mark_valid    = 1'b1;
        bus.mark_accessed = acc;
        bus.mark_dirty    = dty;
        bus.mark_addr     = addr;
        tick();
        bus.mark_valid    = 1'b0;
        bus.mark_accessed = 1'b0;
        bus.mark_dirty    = 1'b0;
        wait_req({tag, " rd"});
        chk({tag, " rd addr"}, 64'(bus.port_req_addr), addr);
        chk({tag, " rd store"}, 64'(bus.port_req_store), 64'd0);
        accept();
        respond(old);
        if (exp_store) begin
            wait_req({tag, " wr"});
            chk({tag, " wr store"}, 64'(bus.port_req_store), 64'd1);
            chk({tag, " wr addr"}, 64'(bus.port_req_addr), addr);
            chk({tag, " wdata"}, bus.port_req_wdata, exp_wdata);
            accept();
            chk({tag, " rsp early"}, 64'(bus.mark_rsp_valid), 64'd0);
            respond(64'd0);
        end
        chk({tag, " no req"}, 64'(bus.port_req_valid), 64'd0);
        chk({tag, " rsp pre"}, 64'(bus.mark_rsp_valid), 64'd0);
        tick();
        chk({tag, " rsp"}, 64'(bus.mark_rsp_valid), 64'd1);
        chk({tag, " stores"}, 64'(n_st - st0), 64'(exp_store));
        tick();
        chk({tag, " rsp drop"}, 64'(bus.mark_rsp_valid), 64'd0);
        chk({tag, " rsp count"}, 64'(n_mark - mk0), 64'd1);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int rd0;
        int st0;
        int mk0;

        reset              = 1'b1;
        bus.pte_req_valid  = 1'b0;
        bus.pte_req_addr   = '0;
        bus.mark_valid     = 1'b0;
        bus.mark_accessed  = 1'b0;
        bus.mark_dirty     = 1'b0;
        bus.mark_addr      = '0;
        bus.port_req_ready = 1'b0;
        bus.port_rsp_valid = 1'b0;
        bus.port_rsp_data  = '0;
        repeat (3) tick();

        chk("rst port valid", 64'(bus.port_req_valid), 64'd0);
        chk("rst port addr", 64'(bus.port_req_addr), 64'd0);
        chk("rst port store", 64'(bus.port_req_store), 64'd0);
        chk("rst port wdata", bus.port_req_wdata, 64'd0);
        chk("rst pte valid", 64'(bus.pte_rsp_valid), 64'd0);
        chk("rst pte data", bus.pte_rsp_data, 64'd0);
        chk("rst mark rsp", 64'(bus.mark_rsp_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // Plain PTE read with minimum request latency.
        rd0 = n_rd;
        st0 = n_st;
        bus.pte_req_valid = 1'b1;
        bus.pte_req_addr  = 32'h8000_100F;
        tick();
        bus.pte_req_valid = 1'b0;
        bus.pte_req_addr  = '0;
        chk("rd req cycle1", 64'(bus.port_req_valid), 64'd1);
        chk("rd req addr", 64'(bus.port_req_addr), 64'h8000_1008);
        chk("rd req store", 64'(bus.port_req_store), 64'd0);
        chk("rd busy", 64'(busy), 64'd1);
        accept();
        chk("rd req drop", 64'(bus.port_req_valid), 64'd0);
        tick();
        tick();
        chk("rd rsp early", 64'(bus.pte_rsp_valid), 64'd0);
        respond(64'h0000_0000_2000_0401);
        chk("rd rsp valid", 64'(bus.pte_rsp_valid), 64'd1);
        chk("rd rsp data", bus.pte_rsp_data,
            64'h0000_0000_2000_0401);
        tick();
        chk("rd rsp pulse", 64'(bus.pte_rsp_valid), 64'd0);
        chk("rd reads", 64'(n_rd - rd0), 64'd1);
        chk("rd stores", 64'(n_st - st0), 64'd0);
        chk("rd seen addr", 64'(last_addr), 64'h8000_1008);

        // Read-modify-write variants.
        do_mark("mark A", 1'b1, 1'b0, 64'h8000_2000,
                64'h08F, 1'b1, 64'h0CF);
        do_mark("mark D", 1'b0, 1'b1, 64'h8000_2008,
                64'h00F, 1'b1, 64'h0CF);
        do_mark("already set", 1'b0, 1'b1, 64'h8000_2010,
                64'h0CF, 1'b0, 64'h0);
        do_mark("invalid set", 1'b1, 1'b1, 64'h8000_2018,
                64'h0CE, 1'b0, 64'h0);
        do_mark("invalid clr", 1'b0, 1'b1, 64'h8000_2020,
                64'h00E, 1'b0, 64'h0);
        do_mark("keep bits", 1'b1, 1'b0, 64'h8000_2028,
                64'hFFFF_0000_1234_5F3F, 1'b1,
                64'hFFFF_0000_1234_5F7F);

        // Mark with neither bit requested: no memory traffic.
        rd0 = n_rd;
        mk0 = n_mark;
        bus.mark_valid = 1'b1;
        bus.mark_addr  = 64'h8000_2030;
        tick();
        bus.mark_valid = 1'b0;
        chk("nop cycle1 req", 64'(bus.port_req_valid), 64'd0);
        chk("nop cycle1 rsp", 64'(bus.mark_rsp_valid), 64'd0);
        chk("nop cycle1 busy", 64'(busy), 64'd1);
        tick();
        chk("nop cycle2 rsp", 64'(bus.mark_rsp_valid), 64'd1);
        tick();
        chk("nop rsp pulse", 64'(bus.mark_rsp_valid), 64'd0);
        chk("nop reads", 64'(n_rd - rd0), 64'd0);
        chk("nop count", 64'(n_mark - mk0), 64'd1);

        // Simultaneous mark and read under port backpressure.
        mk0 = n_mark;
        bus.mark_valid    = 1'b1;
        bus.mark_accessed = 1'b1;
        bus.mark_addr     = 64'h8000_3000;
        bus.pte_req_valid = 1'b1;
        bus.pte_req_addr  = 32'h8000_4010;
        tick();
        bus.mark_valid    = 1'b0;
        bus.mark_accessed = 1'b0;
        bus.pte_req_valid = 1'b0;
        bus.pte_req_addr  = '0;
        for (int i = 0; i < 5; i++) begin
            chk("stall hold",
                {bus.port_req_valid, bus.port_req_store,
                 bus.port_req_addr},
                {1'b1, 1'b0, 32'h8000_3000});
            tick();
        end
        accept();
        respond(64'h001);
        wait_req("coll wr");
        chk("coll wr store", 64'(bus.port_req_store), 64'd1);
        chk("coll wr addr", 64'(bus.port_req_addr), 64'h8000_3000);
        chk("coll wdata", bus.port_req_wdata, 64'h041);
        accept();
        respond(64'd0);
        tick();
        chk("coll mark rsp", 64'(bus.mark_rsp_valid), 64'd1);
        chk("coll rd held", 64'(bus.port_req_valid), 64'd0);
        chk("coll busy", 64'(busy), 64'd1);
        wait_req("coll rd");
        chk("coll mark first", 64'(n_mark - mk0), 64'd1);
        chk("coll rd addr", 64'(bus.port_req_addr), 64'h8000_4010);
        chk("coll rd store", 64'(bus.port_req_store), 64'd0);
        accept();
        respond(64'hDEAD_BEEF_0000_0001);
        chk("coll pte valid", 64'(bus.pte_rsp_valid), 64'd1);
        chk("coll pte data", bus.pte_rsp_data,
            64'hDEAD_BEEF_0000_0001);
        tick();
        chk("coll idle", 64'(busy), 64'd0);

        // Reset while the mark store is waiting for the port.
        bus.mark_valid = 1'b1;
        bus.mark_dirty = 1'b1;
        bus.mark_addr  = 64'h8000_5000;
        tick();
        bus.mark_valid = 1'b0;
        bus.mark_dirty = 1'b0;
        wait_req("rst rd");
        accept();
        respond(64'h001);
        chk("rst in wr req", 64'(bus.port_req_store), 64'd1);
        chk("rst in wr valid", 64'(bus.port_req_valid), 64'd1);
        mk0 = n_mark;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst drop valid", 64'(bus.port_req_valid), 64'd0);
        chk("rst drop busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("rst no mark rsp", 64'(n_mark - mk0), 64'd0);
        chk("rst still idle", 64'(bus.port_req_valid), 64'd0);

        // A fresh read after reset completes normally.
        bus.pte_req_valid = 1'b1;
        bus.pte_req_addr  = 32'h8000_6008;
        tick();
        bus.pte_req_valid = 1'b0;
        chk("post rst req", 64'(bus.port_req_valid), 64'd1);
        chk("post rst addr", 64'(bus.port_req_addr), 64'h8000_6008);
        accept();
        respond(64'h1234_5678_9ABC_DEF1);
        chk("post rst valid", 64'(bus.pte_rsp_valid), 64'd1);
        chk("post rst data", bus.pte_rsp_data,
            64'h1234_5678_9ABC_DEF1);
        tick();
        chk("post rst idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
